uart_rx_frame_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_frame_fsm_if.sv | 35 +++
 rtl/uart_tmr_vote.sv | 11 +
 rtl/uart_rx_frame_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_frame_fsm.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART RX definitions: one-hot frame states, parity encodings and data-bit limits.
package uart_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP1  = 6'b010000,
        ST_STOP2  = 6'b100000
    } rx_state_t;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;

    // Encodings 5..7 behave as no parity.
    function automatic logic parity_enabled(input logic [2:0] mode);
        return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < 4'(DATA_BITS_MIN)) return 4'(DATA_BITS_MIN);
        if (req > max_bits)          return max_bits;
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_frame_fsm_if.sv
// Strobe, configuration and status bundle between the RX sampler and the frame controller.
interface uart_rx_frame_fsm_if #(
    parameter int unsigned MAX_DATA_BITS = 9
);
    logic                     rx_synch_i;
    logic                     bit_synch_i;
    logic                     bit_value_i;
    logic                     acq_sig_i;
    logic [3:0]               data_bits_i;
    logic [2:0]               parity_mode_i;
    logic                     stop_bits_i;
    logic [5:0]               state_o;
    logic [3:0]               bit_counter_o;
    logic                     parity_cal_trigger_o;
    logic [MAX_DATA_BITS-1:0] data_o;
    logic                     data_valid_o;
    logic                     parity_err_o;
    logic                     frame_err_o;
    logic                     break_o;
    logic                     timeout_o;

    modport master (
        output rx_synch_i, bit_synch_i, bit_value_i, acq_sig_i,
        output data_bits_i, parity_mode_i, stop_bits_i,
        input  state_o, bit_counter_o, parity_cal_trigger_o, data_o,
        input  data_valid_o, parity_err_o, frame_err_o, break_o, timeout_o
    );

    modport slave (
        input  rx_synch_i, bit_synch_i, bit_value_i, acq_sig_i,
        input  data_bits_i, parity_mode_i, stop_bits_i,
        output state_o, bit_counter_o, parity_cal_trigger_o, data_o,
        output data_valid_o, parity_err_o, frame_err_o, break_o, timeout_o
    );
endinterface

// File: rtl/uart_tmr_vote.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
module uart_tmr_vote #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_y
);
    assign o_y = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);
endmodule

// File: rtl/uart_rx_frame_fsm.sv
// UART RX frame controller: 5..9 data bits, parity, 1/2 stop bits, break and watchdog.
// Define RX_FSM_TMR_EN to triplicate state, bit counter and watchdog behind majority voters.
module uart_rx_frame_fsm
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned WDT_TICKS     = 48,
    parameter int unsigned WDT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_frame_fsm_if.slave rx_if
);

    rx_state_t          w_state, w_state_nxt;
    logic [3:0]         w_cnt, w_cnt_nxt;
    logic [WDT_W-1:0]   w_wdt, w_wdt_nxt;
    logic               w_start_frame, w_done, w_timeout, w_last_bit;
    logic               w_par_exp, w_par_err_n, w_frm_err_n, w_brk_n;

    logic [3:0]               r_nbits;
    logic [2:0]               r_pmode;
    logic                     r_stop2;
    logic [MAX_DATA_BITS-1:0] r_shift, r_data;
    logic                     r_par_acc, r_all_zero;
    logic                     r_par_err_p, r_frm_err_p, r_brk_p;
    logic                     r_par_err, r_frm_err, r_brk, r_valid, r_timeout;

`ifdef RX_FSM_TMR_EN
    rx_state_t        r_state_cp [3];
    logic [3:0]       r_cnt_cp   [3];
    logic [WDT_W-1:0] r_wdt_cp   [3];
    logic [5:0]       w_state_vote;

    uart_tmr_vote #(.W(6)) u_vote_state (
        .i_a(r_state_cp[0]), .i_b(r_state_cp[1]), .i_c(r_state_cp[2]), .o_y(w_state_vote)
    );
    uart_tmr_vote #(.W(4)) u_vote_cnt (
        .i_a(r_cnt_cp[0]), .i_b(r_cnt_cp[1]), .i_c(r_cnt_cp[2]), .o_y(w_cnt)
    );
    uart_tmr_vote #(.W(WDT_W)) u_vote_wdt (
        .i_a(r_wdt_cp[0]), .i_b(r_wdt_cp[1]), .i_c(r_wdt_cp[2]), .o_y(w_wdt)
    );
    assign w_state = rx_state_t'(w_state_vote);

    // Every copy reloads from the next value derived from the voted state, scrubbing upsets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_state_cp[i] <= ST_IDLE;
                r_cnt_cp[i]   <= '0;
                r_wdt_cp[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state_cp[i] <= w_state_nxt;
                r_cnt_cp[i]   <= w_cnt_nxt;
                r_wdt_cp[i]   <= w_wdt_nxt;
            end
        end
    end
`else
    rx_state_t        r_state;
    logic [3:0]       r_cnt;
    logic [WDT_W-1:0] r_wdt;

    assign w_state = r_state;
    assign w_cnt   = r_cnt;
    assign w_wdt   = r_wdt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wdt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdt   <= w_wdt_nxt;
        end
    end
`endif

    assign w_last_bit = (w_cnt == (r_nbits - 4'd1));

    // Next-state, bit counter and watchdog.
    always_comb begin
        w_state_nxt   = w_state;
        w_cnt_nxt     = w_cnt;
        w_wdt_nxt     = w_wdt;
        w_start_frame = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;

        if (w_state != ST_IDLE) begin
            if (rx_if.bit_synch_i) begin
                w_wdt_nxt = '0;
            end else if (rx_if.acq_sig_i) begin
                if (w_wdt == WDT_W'(WDT_TICKS - 1)) w_timeout = 1'b1;
                else                                w_wdt_nxt = w_wdt + WDT_W'(1);
            end
        end

        case (w_state)
            ST_IDLE: begin
                w_wdt_nxt = '0;
                if (rx_if.rx_synch_i) begin
                    w_state_nxt   = ST_START;
                    w_start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (rx_if.bit_synch_i) begin
                    if (rx_if.bit_value_i) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_if.bit_synch_i) begin
                    w_cnt_nxt = w_cnt + 4'd1;
                    if (w_last_bit)
                        w_state_nxt = parity_enabled(r_pmode) ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (rx_if.bit_synch_i) w_state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (rx_if.bit_synch_i) begin
                    if (r_stop2) begin
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (rx_if.bit_synch_i) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wdt_nxt   = '0;
            end
        endcase

        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_wdt_nxt   = '0;
        end
    end

    always_comb begin
        case (r_pmode)
            PAR_EVEN: w_par_exp = r_par_acc;
            PAR_ODD:  w_par_exp = ~r_par_acc;
            PAR_MARK: w_par_exp = 1'b1;
            default:  w_par_exp = 1'b0;
        endcase
    end

    // Pending flags including this cycle's strobe, so completion captures the final stop bit.
    assign w_par_err_n = r_par_err_p | ((w_state == ST_PARITY) && rx_if.bit_synch_i &&
                                        (rx_if.bit_value_i != w_par_exp));
    assign w_frm_err_n = r_frm_err_p | (((w_state == ST_STOP1) || (w_state == ST_STOP2)) &&
                                        rx_if.bit_synch_i && !rx_if.bit_value_i);
    assign w_brk_n     = r_brk_p | ((w_state == ST_STOP1) && rx_if.bit_synch_i &&
                                    r_all_zero && !rx_if.bit_value_i);

    // Frame datapath and registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nbits     <= 4'(DATA_BITS_MIN);
            r_pmode     <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_shift     <= '0;
            r_data      <= '0;
            r_par_acc   <= 1'b0;
            r_all_zero  <= 1'b1;
            r_par_err_p <= 1'b0;
            r_frm_err_p <= 1'b0;
            r_brk_p     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_brk       <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid   <= w_done;
            r_timeout <= w_timeout;
            if (w_start_frame) begin
                r_nbits     <= clamp_bits(rx_if.data_bits_i, 4'(MAX_DATA_BITS));
                r_pmode     <= rx_if.parity_mode_i;
                r_stop2     <= rx_if.stop_bits_i;
                r_shift     <= '0;
                r_par_acc   <= 1'b0;
                r_all_zero  <= 1'b1;
                r_par_err_p <= 1'b0;
                r_frm_err_p <= 1'b0;
                r_brk_p     <= 1'b0;
            end else if (rx_if.bit_synch_i) begin
                if (w_state == ST_DATA) begin
                    for (int unsigned i = 0; i < MAX_DATA_BITS; i++)
                        if (w_cnt == 4'(i)) r_shift[i] <= rx_if.bit_value_i;
                    r_par_acc  <= r_par_acc ^ rx_if.bit_value_i;
                    r_all_zero <= r_all_zero & ~rx_if.bit_value_i;
                end
                if (w_state == ST_PARITY)
                    r_all_zero <= r_all_zero & ~rx_if.bit_value_i;
                r_par_err_p <= w_par_err_n;
                r_frm_err_p <= w_frm_err_n;
                r_brk_p     <= w_brk_n;
            end
            if (w_done) begin
                r_data    <= r_shift;
                r_par_err <= w_par_err_n;
                r_frm_err <= w_frm_err_n;
                r_brk     <= w_brk_n;
            end
        end
    end

    assign rx_if.state_o              = w_state;
    assign rx_if.bit_counter_o        = w_cnt;
    assign rx_if.parity_cal_trigger_o = (w_state == ST_DATA) && rx_if.bit_synch_i && w_last_bit;
    assign rx_if.data_o               = r_data;
    assign rx_if.data_valid_o         = r_valid;
    assign rx_if.parity_err_o         = r_par_err;
    assign rx_if.frame_err_o          = r_frm_err;
    assign rx_if.break_o              = r_brk;
    assign rx_if.timeout_o            = r_timeout;

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Directed self-checking bench for uart_rx_frame_fsm (default 9-bit, 48-tick watchdog build).
module tb_uart_rx_frame_fsm;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_frame_fsm_if #(.MAX_DATA_BITS(9)) rx_if ();

    uart_rx_frame_fsm #(.MAX_DATA_BITS(9), .WDT_TICKS(48), .WDT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int n_timeout = 0;
    int n_trig = 0;
    logic [3:0] trig_cnt_at = '0;
    logic [5:0] state_at_valid = '0;

    // Event monitor; values seen at posedge are the settled pre-edge values.
    always @(posedge clk) begin
        if (rx_if.data_valid_o) begin
            n_valid++;
            state_at_valid = rx_if.state_o;
        end
        if (rx_if.timeout_o) n_timeout++;
        if (rx_if.parity_cal_trigger_o) begin
            n_trig++;
            trig_cnt_at = rx_if.bit_counter_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rx();
        rx_if.rx_synch_i = 1'b1;
        @(negedge clk);
        rx_if.rx_synch_i = 1'b0;
        tick(1);
    endtask

    task automatic pulse_bit(input logic v);
        rx_if.bit_value_i = v;
        rx_if.bit_synch_i = 1'b1;
        @(negedge clk);
        rx_if.bit_synch_i = 1'b0;
        rx_if.bit_value_i = 1'b0;
        tick(2);
    endtask

    task automatic send_body(input logic [8:0] d, input int n, input logic has_par, input logic pbit,
                             input logic s1, input logic has_s2, input logic s2);
        pulse_bit(1'b0);
        for (int i = 0; i < n; i++) pulse_bit(d[i]);
        if (has_par) pulse_bit(pbit);
        pulse_bit(s1);
        if (has_s2) pulse_bit(s2);
        tick(2);
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [2:0] pm, input logic sb);
        rx_if.data_bits_i   = nb;
        rx_if.parity_mode_i = pm;
        rx_if.stop_bits_i   = sb;
    endtask

    int v0, t0, g0;

    initial begin
        rst = 1'b1;
        rx_if.rx_synch_i  = 1'b0;
        rx_if.bit_synch_i = 1'b0;
        rx_if.bit_value_i = 1'b0;
        rx_if.acq_sig_i   = 1'b0;
        set_cfg(4'd8, PAR_NONE, 1'b0);
        tick(3);
        check_eq("rst_state", 32'(rx_if.state_o), 32'h01);
        check_eq("rst_cnt", 32'(rx_if.bit_counter_o), 32'h0);
        check_eq("rst_data", 32'(rx_if.data_o), 32'h0);
        check_eq("rst_flags", {27'd0, rx_if.data_valid_o, rx_if.parity_err_o, rx_if.frame_err_o,
                               rx_if.break_o, rx_if.timeout_o}, 32'h0);
        rst = 1'b0;
        tick(2);

        // 8N1 0xA5
        v0 = n_valid; g0 = n_trig;
        pulse_rx();
        check_eq("start_state", 32'(rx_if.state_o), 32'h02);
        send_body(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("8n1_data", 32'(rx_if.data_o), 32'h0A5);
        check_eq("8n1_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("8n1_flags", {29'd0, rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o}, 32'h0);
        check_eq("8n1_trig_cnt", 32'(n_trig - g0), 32'd1);
        check_eq("8n1_trig_idx", 32'(trig_cnt_at), 32'd7);
        check_eq("8n1_valid_in_idle", 32'(state_at_valid), 32'h01);

        // 7E1 0x41 with wrong parity bit 1
        set_cfg(4'd7, PAR_EVEN, 1'b0);
        pulse_rx();
        send_body(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("7e1_data", 32'(rx_if.data_o), 32'h041);
        check_eq("7e1_par_err", 32'(rx_if.parity_err_o), 32'h1);
        check_eq("7e1_frm_err", 32'(rx_if.frame_err_o), 32'h0);

        // 9O2 0x1FF, correct parity 0, STOP2 = 0
        set_cfg(4'd9, PAR_ODD, 1'b1);
        v0 = n_valid;
        pulse_rx();
        send_body(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("9o2_data", 32'(rx_if.data_o), 32'h1FF);
        check_eq("9o2_frm_err", 32'(rx_if.frame_err_o), 32'h1);
        check_eq("9o2_par_err", 32'(rx_if.parity_err_o), 32'h0);
        check_eq("9o2_brk", 32'(rx_if.break_o), 32'h0);
        check_eq("9o2_valid_cnt", 32'(n_valid - v0), 32'd1);

        // False start
        v0 = n_valid;
        pulse_rx();
        rx_if.bit_value_i = 1'b1;
        rx_if.bit_synch_i = 1'b1;
        @(negedge clk);
        rx_if.bit_synch_i = 1'b0;
        rx_if.bit_value_i = 1'b0;
        check_eq("false_start_state", 32'(rx_if.state_o), 32'h01);
        tick(3);
        check_eq("false_start_valid", 32'(n_valid - v0), 32'd0);
        check_eq("false_start_flags_held", 32'(rx_if.frame_err_o), 32'h1);

        // Clamp 3 -> 5 bits, config changes mid-frame ignored
        set_cfg(4'd3, PAR_NONE, 1'b0);
        pulse_rx();
        set_cfg(4'd8, PAR_EVEN, 1'b1);
        send_body(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("clamp_data", 32'(rx_if.data_o), 32'h015);
        check_eq("clamp_flags", {29'd0, rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o}, 32'h0);

        // Reset mid-frame
        set_cfg(4'd8, PAR_NONE, 1'b0);
        pulse_rx();
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        pulse_bit(1'b1);
        check_eq("pre_rst_cnt", 32'(rx_if.bit_counter_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_state", 32'(rx_if.state_o), 32'h01);
        check_eq("midrst_cnt", 32'(rx_if.bit_counter_o), 32'h0);
        check_eq("midrst_data", 32'(rx_if.data_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // 8N1 break
        pulse_rx();
        send_body(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("brk_data", 32'(rx_if.data_o), 32'h0);
        check_eq("brk_break", 32'(rx_if.break_o), 32'h1);
        check_eq("brk_frm_err", 32'(rx_if.frame_err_o), 32'h1);

        // Watchdog after 3 data bits
        v0 = n_valid; t0 = n_timeout;
        pulse_rx();
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        pulse_bit(1'b0);
        pulse_bit(1'b1);
        repeat (47) begin
            rx_if.acq_sig_i = 1'b1;
            @(negedge clk);
            rx_if.acq_sig_i = 1'b0;
            @(negedge clk);
        end
        check_eq("wdt_47_state", 32'(rx_if.state_o), 32'h04);
        check_eq("wdt_47_timeout", 32'(n_timeout - t0), 32'd0);
        rx_if.acq_sig_i = 1'b1;
        @(negedge clk);
        rx_if.acq_sig_i = 1'b0;
        check_eq("wdt_48_state", 32'(rx_if.state_o), 32'h01);
        check_eq("wdt_48_pulse", 32'(rx_if.timeout_o), 32'h1);
        tick(3);
        check_eq("wdt_timeout_cnt", 32'(n_timeout - t0), 32'd1);
        check_eq("wdt_no_valid", 32'(n_valid - v0), 32'd0);

`ifdef RX_FSM_TMR_EN
        // Upset one state copy mid-DATA
        v0 = n_valid;
        pulse_rx();
        pulse_bit(1'b0);
        pulse_bit(1'b0);
        pulse_bit(1'b0);
        dut.r_state_cp[1] = ST_STOP1;
        #1;
        check_eq("tmr_voted_state", 32'(rx_if.state_o), 32'h04);
        tick(1);
        for (int i = 2; i < 8; i++) pulse_bit(i inside {2, 3, 4, 5});
        pulse_bit(1'b1);
        tick(2);
        check_eq("tmr_data", 32'(rx_if.data_o), 32'h03C);
        check_eq("tmr_valid_cnt", 32'(n_valid - v0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
